// File: rtl/elevator_ctrl_n.sv
// elevator_ctrl_n - multi-floor elevator car controller.
//
// Floor calls are latched into a pending bitmap and served in SCAN order:
// the car keeps its heading while calls remain beyond it, then reverses.
// Floor-to-floor travel and door dwell are timed with down-counters.
// Power loss, emergency stop and overweight (door hold) are handled here.
//
// Ports:
//   clk           rising-edge clock
//   reset         asynchronous active-low reset
//   power_ok      mains/generator present (0 forces NO_POWER)
//   emer_stop     emergency stop, level sensitive
//   peak_hour     suppresses the overweight door hold
//   call_valid    call strobe, one call per cycle
//   call_floor    requested floor
//   total_weight  car load sensor
//   door_obstruct door sensor blocked
//   cur_floor     current floor (registered)
//   direction     00 none, 01 up, 10 down (registered)
//   moving        car travelling (registered)
//   door_open     door command (registered)
//   weight_alert  load at/over threshold outside peak hour (combinational)
//   pending       outstanding call bitmap (registered)
//   call_err      one-cycle pulse for a rejected call (registered)
module elevator_ctrl_n #(
  parameter int NUM_FLOORS    = 16,
  parameter int FLOOR_W       = 4,
  parameter int WEIGHT_W      = 10,
  parameter int MAX_WEIGHT    = 1000,
  parameter int TRAVEL_CYCLES = 4,
  parameter int DOOR_CYCLES   = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  power_ok,
  input  logic                  emer_stop,
  input  logic                  peak_hour,
  input  logic                  call_valid,
  input  logic [FLOOR_W-1:0]    call_floor,
  input  logic [WEIGHT_W-1:0]   total_weight,
  input  logic                  door_obstruct,
  output logic [FLOOR_W-1:0]    cur_floor,
  output logic [1:0]            direction,
  output logic                  moving,
  output logic                  door_open,
  output logic                  weight_alert,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  call_err
);

  typedef enum logic [2:0] {
    ST_NO_POWER  = 3'd0,
    ST_IDLE      = 3'd1,
    ST_MOVE      = 3'd2,
    ST_DOOR_OPEN = 3'd3,
    ST_EMERGENCY = 3'd4
  } state_t;

  localparam logic [1:0] DIR_NONE = 2'b00;
  localparam logic [1:0] DIR_UP   = 2'b01;
  localparam logic [1:0] DIR_DOWN = 2'b10;

  localparam int TCNT_W = $clog2(TRAVEL_CYCLES + 1);
  localparam int DCNT_W = $clog2(DOOR_CYCLES + 1);

  // Counters are loaded with N-1 so that expiry lands exactly N edges later.
  localparam logic [TCNT_W-1:0] TCNT_LOAD = TCNT_W'(TRAVEL_CYCLES - 1);
  localparam logic [TCNT_W-1:0] TCNT_ONE  = TCNT_W'(1);
  localparam logic [TCNT_W-1:0] TCNT_ZERO = {TCNT_W{1'b0}};
  localparam logic [DCNT_W-1:0] DCNT_LOAD = DCNT_W'(DOOR_CYCLES - 1);
  localparam logic [DCNT_W-1:0] DCNT_ONE  = DCNT_W'(1);
  localparam logic [DCNT_W-1:0] DCNT_ZERO = {DCNT_W{1'b0}};

  localparam logic [NUM_FLOORS-1:0] ONE_HOT0   = {{(NUM_FLOORS-1){1'b0}}, 1'b1};
  localparam logic [NUM_FLOORS-1:0] PEND_ZERO  = {NUM_FLOORS{1'b0}};
  localparam logic [FLOOR_W-1:0]    TOP_FLOOR  = FLOOR_W'(NUM_FLOORS - 1);
  localparam logic [FLOOR_W-1:0]    FLOOR_ONE  = FLOOR_W'(1);
  localparam logic [FLOOR_W-1:0]    FLOOR_ZERO = {FLOOR_W{1'b0}};

  // Bitmap of floors strictly below f.
  function automatic logic [NUM_FLOORS-1:0] mask_below(input logic [FLOOR_W-1:0] f);
    mask_below = (ONE_HOT0 << f) - ONE_HOT0;
  endfunction

  // Bitmap of floors strictly above f.
  function automatic logic [NUM_FLOORS-1:0] mask_above(input logic [FLOOR_W-1:0] f);
    mask_above = ~(mask_below(f) | (ONE_HOT0 << f));
  endfunction

  state_t                  state_r;
  logic                    last_up_r;
  logic [TCNT_W-1:0]       tcnt_r;
  logic [DCNT_W-1:0]       dcnt_r;

  logic                    call_in_range_s;
  logic                    call_ok_s;
  logic                    call_here_s;
  logic [NUM_FLOORS-1:0]   call_bits_s;
  logic [NUM_FLOORS-1:0]   pend_next_s;
  logic [NUM_FLOORS-1:0]   cur_bit_s;
  logic                    above_s;
  logic                    below_s;
  logic                    at_edge_s;
  logic [FLOOR_W-1:0]      next_floor_s;
  logic [NUM_FLOORS-1:0]   next_bit_s;
  logic                    arrive_hit_s;
  logic                    beyond_s;

  assign weight_alert = (total_weight >= WEIGHT_W'(MAX_WEIGHT)) && !peak_hour;

  // Call qualification plus look-ahead for planning and arrival decisions
  always_comb begin
    call_in_range_s = (32'(call_floor) < 32'(NUM_FLOORS));
    call_ok_s       = call_valid && call_in_range_s && (state_r != ST_NO_POWER);
    // A call to the floor the car is standing at is served by the door, not latched.
    call_here_s     = call_ok_s && (call_floor == cur_floor) &&
                      ((state_r == ST_IDLE) || (state_r == ST_DOOR_OPEN));
    if (call_ok_s && !call_here_s) begin
      call_bits_s = ONE_HOT0 << call_floor;
    end else begin
      call_bits_s = PEND_ZERO;
    end
    pend_next_s = pending | call_bits_s;
    cur_bit_s   = ONE_HOT0 << cur_floor;
    above_s     = |(pending & mask_above(cur_floor));
    below_s     = |(pending & mask_below(cur_floor));

    if (direction == DIR_UP) begin
      at_edge_s    = (cur_floor == TOP_FLOOR);
      next_floor_s = cur_floor + FLOOR_ONE;
    end else if (direction == DIR_DOWN) begin
      at_edge_s    = (cur_floor == FLOOR_ZERO);
      next_floor_s = cur_floor - FLOOR_ONE;
    end else begin
      at_edge_s    = 1'b1;
      next_floor_s = cur_floor;
    end
    next_bit_s   = ONE_HOT0 << next_floor_s;
    arrive_hit_s = |(pend_next_s & next_bit_s);
    if (direction == DIR_DOWN) begin
      beyond_s = |(pend_next_s & mask_below(next_floor_s));
    end else begin
      beyond_s = |(pend_next_s & mask_above(next_floor_s));
    end
  end

  // Controller FSM: power/emergency overrides first, then normal service
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= ST_NO_POWER;
      cur_floor <= FLOOR_ZERO;
      direction <= DIR_NONE;
      moving    <= 1'b0;
      door_open <= 1'b0;
      pending   <= PEND_ZERO;
      call_err  <= 1'b0;
      last_up_r <= 1'b1;
      tcnt_r    <= TCNT_ZERO;
      dcnt_r    <= DCNT_ZERO;
    end else begin
      call_err <= call_valid && (!call_in_range_s || (state_r == ST_NO_POWER));

      if (!power_ok) begin
        state_r   <= ST_NO_POWER;
        direction <= DIR_NONE;
        moving    <= 1'b0;
        door_open <= 1'b0;
        pending   <= PEND_ZERO;
        tcnt_r    <= TCNT_ZERO;
        dcnt_r    <= DCNT_ZERO;
      end else if (emer_stop) begin
        state_r   <= ST_EMERGENCY;
        direction <= DIR_NONE;
        moving    <= 1'b0;
        tcnt_r    <= TCNT_ZERO;
        pending   <= pend_next_s;
        // Door may only open if the car is level with a floor.
        case (state_r)
          ST_IDLE, ST_DOOR_OPEN: door_open <= 1'b1;
          ST_EMERGENCY:          door_open <= door_open;
          default:               door_open <= 1'b0;
        endcase
      end else begin
        case (state_r)
          ST_NO_POWER: begin
            state_r <= ST_IDLE;
          end

          ST_IDLE: begin
            if (call_here_s || (|(pending & cur_bit_s))) begin
              state_r   <= ST_DOOR_OPEN;
              door_open <= 1'b1;
              dcnt_r    <= DCNT_LOAD;
              pending   <= pend_next_s & ~cur_bit_s;
            end else if (|pending) begin
              state_r <= ST_MOVE;
              moving  <= 1'b1;
              tcnt_r  <= TCNT_LOAD;
              pending <= pend_next_s;
              if (last_up_r && above_s) begin
                direction <= DIR_UP;
                last_up_r <= 1'b1;
              end else if (below_s) begin
                direction <= DIR_DOWN;
                last_up_r <= 1'b0;
              end else begin
                direction <= DIR_UP;
                last_up_r <= 1'b1;
              end
            end else begin
              pending   <= pend_next_s;
              direction <= DIR_NONE;
            end
          end

          ST_MOVE: begin
            pending <= pend_next_s;
            if (tcnt_r != TCNT_ZERO) begin
              tcnt_r <= tcnt_r - TCNT_ONE;
            end else if (at_edge_s) begin
              // Never step past the shaft ends; fall back to re-planning.
              state_r   <= ST_IDLE;
              moving    <= 1'b0;
              direction <= DIR_NONE;
            end else begin
              cur_floor <= next_floor_s;
              if (arrive_hit_s) begin
                // Clearing wins over a same-cycle call: the open door serves it.
                pending   <= pend_next_s & ~next_bit_s;
                state_r   <= ST_DOOR_OPEN;
                door_open <= 1'b1;
                moving    <= 1'b0;
                dcnt_r    <= DCNT_LOAD;
              end else if (beyond_s) begin
                tcnt_r <= TCNT_LOAD;
              end else begin
                state_r   <= ST_IDLE;
                moving    <= 1'b0;
                direction <= DIR_NONE;
              end
            end
          end

          ST_DOOR_OPEN: begin
            pending <= pend_next_s;
            if (call_here_s || door_obstruct || weight_alert) begin
              dcnt_r <= DCNT_LOAD;
            end else if (dcnt_r == DCNT_ZERO) begin
              state_r   <= ST_IDLE;
              door_open <= 1'b0;
              direction <= DIR_NONE;
            end else begin
              dcnt_r <= dcnt_r - DCNT_ONE;
            end
          end

          ST_EMERGENCY: begin
            state_r   <= ST_IDLE;
            door_open <= 1'b0;
            direction <= DIR_NONE;
            pending   <= pend_next_s;
          end

          default: begin
            state_r   <= ST_NO_POWER;
            direction <= DIR_NONE;
            moving    <= 1'b0;
            door_open <= 1'b0;
            pending   <= PEND_ZERO;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_elevator_ctrl_n.sv
module tb_elevator_ctrl_n;
  localparam int NF   = 10;
  localparam int FW   = 4;
  localparam int WW   = 10;
  localparam int MAXW = 1000;
  localparam int TC   = 4;
  localparam int DC   = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          power_ok = 1'b0;
  logic          emer_stop = 1'b0;
  logic          peak_hour = 1'b0;
  logic          call_valid = 1'b0;
  logic [FW-1:0] call_floor = '0;
  logic [WW-1:0] total_weight = '0;
  logic          door_obstruct = 1'b0;
  logic [FW-1:0] cur_floor;
  logic [1:0]    direction;
  logic          moving;
  logic          door_open;
  logic          weight_alert;
  logic [NF-1:0] pending;
  logic          call_err;

  int n_checks = 0;
  int n_fail   = 0;

  elevator_ctrl_n #(
    .NUM_FLOORS(NF), .FLOOR_W(FW), .WEIGHT_W(WW), .MAX_WEIGHT(MAXW),
    .TRAVEL_CYCLES(TC), .DOOR_CYCLES(DC)
  ) dut (
    .clk(clk), .reset(reset), .power_ok(power_ok), .emer_stop(emer_stop),
    .peak_hour(peak_hour), .call_valid(call_valid), .call_floor(call_floor),
    .total_weight(total_weight), .door_obstruct(door_obstruct),
    .cur_floor(cur_floor), .direction(direction), .moving(moving),
    .door_open(door_open), .weight_alert(weight_alert), .pending(pending),
    .call_err(call_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_in(input logic pwr, input logic emer, input logic cv, input logic [3:0] cf,
                        input logic [9:0] wt, input logic pk, input logic obs);
    power_ok = pwr; emer_stop = emer; call_valid = cv; call_floor = cf;
    total_weight = wt; peak_hour = pk; door_obstruct = obs;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    set_in(1'b0, 1'b0, 1'b0, 4'd0, 10'd0, 1'b0, 1'b0);
    step();
    step();
    reset = 1'b1;
  endtask

  task automatic power_on();
    power_ok = 1'b1;
    step();
  endtask

  task automatic one_call(input logic [3:0] f);
    call_valid = 1'b1; call_floor = f;
    step();
    call_valid = 1'b0;
  endtask

  // ---------------- behavioural reference model ----------------
  localparam int M_OFF = 0, M_IDLE = 1, M_MOVE = 2, M_DOOR = 3, M_STOP = 4;
  int       m_mode, m_floor, m_step, m_elapsed;
  bit       m_last_up, m_moving, m_door, m_err;
  bit [1:0] m_dir;
  bit       m_req [NF];
  bit       w_up, w_dn, w_any, w_here, w_ok, w_hereall, w_add, w_inr, w_wa;

  function automatic bit any_req(input int lo, input int hi);
    for (int f = lo; f <= hi; f++) begin
      if (f >= 0 && f < NF && m_req[f]) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic logic [NF-1:0] req_vec();
    logic [NF-1:0] v;
    v = '0;
    for (int f = 0; f < NF; f++) v[f] = m_req[f];
    return v;
  endfunction

  task automatic model_reset();
    m_mode = M_OFF; m_floor = 0; m_step = 0; m_elapsed = 0;
    m_last_up = 1'b1; m_moving = 1'b0; m_door = 1'b0; m_err = 1'b0; m_dir = 2'b00;
    for (int f = 0; f < NF; f++) m_req[f] = 1'b0;
  endtask

  task automatic model_step();
    w_inr     = int'(call_floor) < NF;
    w_ok      = call_valid && w_inr && (m_mode != M_OFF);
    w_hereall = w_ok && (int'(call_floor) == m_floor) && (m_mode == M_IDLE || m_mode == M_DOOR);
    w_add     = w_ok && !w_hereall;
    w_wa      = (int'(total_weight) >= MAXW) && !peak_hour;
    m_err     = call_valid && (!w_inr || m_mode == M_OFF);
    w_up      = any_req(m_floor + 1, NF - 1);
    w_dn      = any_req(0, m_floor - 1);
    w_any     = any_req(0, NF - 1);
    w_here    = m_req[m_floor];
    if (w_add) m_req[call_floor] = 1'b1;
    if (!power_ok) begin
      m_mode = M_OFF; m_moving = 1'b0; m_door = 1'b0; m_dir = 2'b00; m_elapsed = 0;
      for (int f = 0; f < NF; f++) m_req[f] = 1'b0;
    end else if (emer_stop) begin
      if (m_mode == M_IDLE || m_mode == M_DOOR) m_door = 1'b1;
      else if (m_mode != M_STOP) m_door = 1'b0;
      m_mode = M_STOP; m_moving = 1'b0; m_dir = 2'b00;
    end else begin
      case (m_mode)
        M_OFF: m_mode = M_IDLE;
        M_IDLE: begin
          if (w_hereall || w_here) begin
            m_req[m_floor] = 1'b0; m_mode = M_DOOR; m_door = 1'b1; m_elapsed = 0;
          end else if (w_any) begin
            if (m_last_up && w_up) m_step = 1;
            else if (w_dn) m_step = -1;
            else m_step = 1;
            m_last_up = (m_step > 0);
            m_dir = (m_step > 0) ? 2'b01 : 2'b10;
            m_mode = M_MOVE; m_moving = 1'b1; m_elapsed = 0;
          end else begin
            m_dir = 2'b00;
          end
        end
        M_MOVE: begin
          m_elapsed++;
          if (m_elapsed == TC) begin
            m_elapsed = 0;
            m_floor += m_step;
            if (m_req[m_floor]) begin
              m_req[m_floor] = 1'b0; m_mode = M_DOOR; m_door = 1'b1; m_moving = 1'b0;
            end else if (!((m_step > 0 && any_req(m_floor + 1, NF - 1)) ||
                           (m_step < 0 && any_req(0, m_floor - 1)))) begin
              m_mode = M_IDLE; m_moving = 1'b0; m_dir = 2'b00;
            end
          end
        end
        M_DOOR: begin
          if (w_hereall || door_obstruct || w_wa) begin
            m_elapsed = 0;
          end else begin
            m_elapsed++;
            if (m_elapsed == DC) begin
              m_mode = M_IDLE; m_door = 1'b0; m_dir = 2'b00;
            end
          end
        end
        default: begin
          m_mode = M_IDLE; m_door = 1'b0; m_dir = 2'b00;
        end
      endcase
    end
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) model_reset();
    else model_step();
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic pwr, emer, cv; logic [3:0] cf; logic [9:0] wt; logic pk, obs; int cyc;
    logic [3:0] e_cur; logic [1:0] e_dir; logic e_mv, e_door; logic [9:0] e_pend; logic e_err, e_wa;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(input logic pwr, input logic emer, input logic cv, input logic [3:0] cf,
                              input logic [9:0] wt, input logic pk, input logic obs, input int cyc,
                              input logic [3:0] e_cur, input logic [1:0] e_dir, input logic e_mv,
                              input logic e_door, input logic [9:0] e_pend, input logic e_err,
                              input logic e_wa);
    vec_t v;
    v.pwr = pwr; v.emer = emer; v.cv = cv; v.cf = cf; v.wt = wt; v.pk = pk; v.obs = obs; v.cyc = cyc;
    v.e_cur = e_cur; v.e_dir = e_dir; v.e_mv = e_mv; v.e_door = e_door; v.e_pend = e_pend;
    v.e_err = e_err; v.e_wa = e_wa;
    return v;
  endfunction

  int         n, d;
  logic       prev_door;
  logic [3:0] arr_floor[$];
  logic [1:0] arr_dir[$];

  initial begin
    //          pwr  emr  cv   cf     wt       pk   obs  cyc cur   dir    mv   door  pend     err  wa
    tbl.push_back(mk(1'b0,1'b0,1'b1,4'd3, 10'd0,   1'b0,1'b0,1, 4'd0,2'b00,1'b0,1'b0,10'h000,1'b1,1'b0));
    tbl.push_back(mk(1'b1,1'b0,1'b0,4'd0, 10'd0,   1'b0,1'b0,1, 4'd0,2'b00,1'b0,1'b0,10'h000,1'b0,1'b0));
    tbl.push_back(mk(1'b1,1'b0,1'b1,4'd15,10'd0,   1'b0,1'b0,1, 4'd0,2'b00,1'b0,1'b0,10'h000,1'b1,1'b0));
    tbl.push_back(mk(1'b1,1'b0,1'b1,4'd2, 10'd0,   1'b0,1'b0,1, 4'd0,2'b00,1'b0,1'b0,10'h004,1'b0,1'b0));
    tbl.push_back(mk(1'b1,1'b0,1'b0,4'd0, 10'd0,   1'b0,1'b0,4, 4'd0,2'b01,1'b1,1'b0,10'h004,1'b0,1'b0));
    tbl.push_back(mk(1'b1,1'b0,1'b0,4'd0, 10'd0,   1'b0,1'b0,4, 4'd1,2'b01,1'b1,1'b0,10'h004,1'b0,1'b0));
    tbl.push_back(mk(1'b1,1'b0,1'b0,4'd0, 10'd0,   1'b0,1'b0,1, 4'd2,2'b01,1'b0,1'b1,10'h000,1'b0,1'b0));
    tbl.push_back(mk(1'b1,1'b0,1'b0,4'd0, 10'd1000,1'b0,1'b0,1, 4'd2,2'b01,1'b0,1'b1,10'h000,1'b0,1'b1));
    tbl.push_back(mk(1'b1,1'b0,1'b0,4'd0, 10'd1000,1'b1,1'b0,1, 4'd2,2'b01,1'b0,1'b1,10'h000,1'b0,1'b0));
    tbl.push_back(mk(1'b1,1'b0,1'b1,4'd2, 10'd0,   1'b0,1'b0,1, 4'd2,2'b01,1'b0,1'b1,10'h000,1'b0,1'b0));
    tbl.push_back(mk(1'b1,1'b0,1'b0,4'd0, 10'd0,   1'b0,1'b0,7, 4'd2,2'b01,1'b0,1'b1,10'h000,1'b0,1'b0));
    tbl.push_back(mk(1'b1,1'b0,1'b0,4'd0, 10'd0,   1'b0,1'b0,1, 4'd2,2'b00,1'b0,1'b0,10'h000,1'b0,1'b0));
    tbl.push_back(mk(1'b1,1'b1,1'b0,4'd0, 10'd0,   1'b0,1'b0,1, 4'd2,2'b00,1'b0,1'b1,10'h000,1'b0,1'b0));
    tbl.push_back(mk(1'b1,1'b1,1'b1,4'd5, 10'd0,   1'b0,1'b0,1, 4'd2,2'b00,1'b0,1'b1,10'h020,1'b0,1'b0));
    tbl.push_back(mk(1'b1,1'b0,1'b0,4'd0, 10'd0,   1'b0,1'b0,1, 4'd2,2'b00,1'b0,1'b0,10'h020,1'b0,1'b0));
    tbl.push_back(mk(1'b1,1'b0,1'b0,4'd0, 10'd0,   1'b0,1'b0,1, 4'd2,2'b01,1'b1,1'b0,10'h020,1'b0,1'b0));
    tbl.push_back(mk(1'b0,1'b0,1'b0,4'd0, 10'd0,   1'b0,1'b0,1, 4'd2,2'b00,1'b0,1'b0,10'h000,1'b0,1'b0));
    tbl.push_back(mk(1'b1,1'b0,1'b0,4'd0, 10'd0,   1'b0,1'b0,1, 4'd2,2'b00,1'b0,1'b0,10'h000,1'b0,1'b0));

    // Reset values while reset is held
    repeat (2) @(negedge clk);
    chk("rst_cur", 32'(cur_floor), 32'd0);
    chk("rst_dir", 32'(direction), 32'd0);
    chk("rst_moving", 32'(moving), 32'd0);
    chk("rst_door", 32'(door_open), 32'd0);
    chk("rst_pending", 32'(pending), 32'd0);
    chk("rst_call_err", 32'(call_err), 32'd0);
    reset = 1'b1;

    // Table-driven sequence
    foreach (tbl[i]) begin
      set_in(tbl[i].pwr, tbl[i].emer, tbl[i].cv, tbl[i].cf, tbl[i].wt, tbl[i].pk, tbl[i].obs);
      for (int c = 0; c < tbl[i].cyc; c++) begin
        step();
        chk($sformatf("vec%0d_cur", i), 32'(cur_floor), 32'(tbl[i].e_cur));
        chk($sformatf("vec%0d_dir", i), 32'(direction), 32'(tbl[i].e_dir));
        chk($sformatf("vec%0d_moving", i), 32'(moving), 32'(tbl[i].e_mv));
        chk($sformatf("vec%0d_door", i), 32'(door_open), 32'(tbl[i].e_door));
        chk($sformatf("vec%0d_pending", i), 32'(pending), 32'(tbl[i].e_pend));
        chk($sformatf("vec%0d_call_err", i), 32'(call_err), 32'(tbl[i].e_err));
        chk($sformatf("vec%0d_weight_alert", i), 32'(weight_alert), 32'(tbl[i].e_wa));
      end
    end

    // A: call floor 5 from floor 0, travel and dwell timing
    do_reset();
    power_on();
    one_call(4'd5);
    chk("A_pending_after_call", 32'(pending), 32'h020);
    step();
    chk("A_moving_next_edge", 32'(moving), 32'd1);
    n = 0;
    while (cur_floor != 4'd5 && n < 100) begin step(); n++; end
    chk("A_travel_cycles", 32'(n), 32'd20);
    chk("A_door_on_arrival", 32'(door_open), 32'd1);
    d = 0;
    while (door_open && d < 100) begin step(); d++; end
    chk("A_door_cycles", 32'(d), 32'(DC));
    chk("A_pending_cleared", 32'(pending), 32'd0);
    chk("A_dir_idle", 32'(direction), 32'd0);

    // B: SCAN order - at floor 3 going up, calls 7 and 1
    do_reset();
    power_on();
    one_call(4'd4);
    n = 0;
    while (cur_floor != 4'd3 && n < 100) begin step(); n++; end
    chk("B_moving_at_3", 32'(moving), 32'd1);
    one_call(4'd7);
    one_call(4'd1);
    prev_door = door_open;
    n = 0;
    while (arr_floor.size() < 3 && n < 300) begin
      step();
      n++;
      if (door_open && !prev_door) begin
        arr_floor.push_back(cur_floor);
        arr_dir.push_back(direction);
      end
      prev_door = door_open;
    end
    chk("B_stops", 32'(arr_floor.size()), 32'd3);
    if (arr_floor.size() == 3) begin
      chk("B_stop0_floor", 32'(arr_floor[0]), 32'd4);
      chk("B_stop1_floor", 32'(arr_floor[1]), 32'd7);
      chk("B_stop1_dir", 32'(arr_dir[1]), 32'b01);
      chk("B_stop2_floor", 32'(arr_floor[2]), 32'd1);
      chk("B_stop2_dir", 32'(arr_dir[2]), 32'b10);
    end

    // C: emergency stop between floors 2 and 3
    do_reset();
    power_on();
    one_call(4'd5);
    n = 0;
    while (cur_floor != 4'd2 && n < 100) begin step(); n++; end
    step();
    emer_stop = 1'b1;
    step();
    chk("C_emer_door", 32'(door_open), 32'd0);
    chk("C_emer_moving", 32'(moving), 32'd0);
    chk("C_emer_floor", 32'(cur_floor), 32'd2);
    repeat (3) step();
    chk("C_emer_floor_held", 32'(cur_floor), 32'd2);
    chk("C_emer_pending", 32'(pending), 32'h020);
    emer_stop = 1'b0;
    n = 0;
    while (!door_open && n < 100) begin step(); n++; end
    chk("C_resume_floor", 32'(cur_floor), 32'd5);

    // D: asynchronous reset during MOVE
    do_reset();
    power_on();
    one_call(4'd8);
    repeat (6) step();
    chk("D_moving_before", 32'(moving), 32'd1);
    reset = 1'b0;
    #1;
    chk("D_async_cur", 32'(cur_floor), 32'd0);
    chk("D_async_dir", 32'(direction), 32'd0);
    chk("D_async_moving", 32'(moving), 32'd0);
    chk("D_async_pending", 32'(pending), 32'd0);
    chk("D_async_door", 32'(door_open), 32'd0);
    #2;
    reset = 1'b1;
    @(negedge clk);

    // E: randomized stimulus against the reference model
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      power_ok      = ($urandom_range(0, 63) != 0);
      if ($urandom_range(0, 39) == 0) emer_stop = ~emer_stop;
      call_valid    = ($urandom_range(0, 5) == 0);
      call_floor    = ($urandom_range(0, 19) == 0) ? 4'd15 : 4'($urandom_range(0, 11));
      door_obstruct = ($urandom_range(0, 9) == 0);
      peak_hour     = ($urandom_range(0, 3) == 0);
      total_weight  = ($urandom_range(0, 14) == 0) ? 10'($urandom_range(990, 1023))
                                                   : 10'($urandom_range(0, 900));
      step();
      chk("rnd_cur", 32'(cur_floor), 32'(m_floor));
      chk("rnd_dir", 32'(direction), 32'(m_dir));
      chk("rnd_moving", 32'(moving), 32'(m_moving));
      chk("rnd_door", 32'(door_open), 32'(m_door));
      chk("rnd_pending", 32'(pending), 32'(req_vec()));
      chk("rnd_call_err", 32'(call_err), 32'(m_err));
      chk("rnd_weight_alert", 32'(weight_alert),
          32'((int'(total_weight) >= MAXW) && !peak_hour));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
